// File: rtl/gf180mcu_nandn_pipe.sv
// Parametrised NCH-channel, NIN-input NAND/AND reduction with a STAGES-deep valid-tracked pipeline.
// Optional change detector on the output word: define GF180MCU_NANDN_PIPE_CHG_DET_EN.
module gf180mcu_nandn_pipe #(
  parameter int NIN    = 3,
  parameter int NCH    = 1,
  parameter int STAGES = 1
) (
`ifdef USE_POWER_PINS
  inout  wire                  VDD,
  inout  wire                  VSS,
`endif
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCH*NIN-1:0]   A,
  input  logic                 MODE,
  input  logic                 VI,
  input  logic                 EN,
  output logic [NCH-1:0]       ZN,
  output logic                 VO
`ifdef GF180MCU_NANDN_PIPE_CHG_DET_EN
  ,
  output logic                 CHG
`endif
);

  generate
    if (NIN < 2 || NIN > 16) begin : g_bad_nin
      $error("gf180mcu_nandn_pipe: NIN must be in 2..16");
    end
    if (NCH < 1 || NCH > 32) begin : g_bad_nch
      $error("gf180mcu_nandn_pipe: NCH must be in 1..32");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("gf180mcu_nandn_pipe: STAGES must be in 1..4");
    end
  endgenerate

  logic [NCH-1:0]    f_p0;
  logic [NCH-1:0]    zn_d [STAGES];
  logic [NCH-1:0]    zn_q [STAGES];
  logic [STAGES-1:0] vld_d;
  logic [STAGES-1:0] vld_q;

  // Stage 0: combinational per-channel reduction, MODE selects NAND or AND
  always_comb begin
    f_p0 = '1;
    for (int c = 0; c < NCH; c++) begin
      f_p0[c] = MODE ? (&A[c*NIN +: NIN]) : ~(&A[c*NIN +: NIN]);
    end
  end

  always_comb begin
    zn_d[0]  = f_p0;
    vld_d[0] = VI;
    for (int s = 1; s < STAGES; s++) begin
      zn_d[s]  = zn_q[s-1];
      vld_d[s] = vld_q[s-1];
    end
  end

  // Stages 1..STAGES: data resets to all-ones, the NAND of all-zero inputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < STAGES; s++) begin
        zn_q[s] <= '1;
      end
      vld_q <= '0;
    end else if (EN) begin
      for (int s = 0; s < STAGES; s++) begin
        zn_q[s] <= zn_d[s];
      end
      vld_q <= vld_d;
    end
  end

  assign ZN = zn_q[STAGES-1];
  assign VO = vld_q[STAGES-1];

`ifdef GF180MCU_NANDN_PIPE_CHG_DET_EN
  logic [NCH-1:0] shadow_q, shadow_d;
  logic           seen_q, seen_d;
  logic           chg_q, chg_d;

  // seen_q forces a flag on the first valid word even when it equals the all-ones shadow
  always_comb begin
    shadow_d = shadow_q;
    seen_d   = seen_q;
    chg_d    = chg_q;
    if (EN) begin
      chg_d = 1'b0;
      if (vld_d[STAGES-1] && (!seen_q || (zn_d[STAGES-1] != shadow_q))) begin
        chg_d    = 1'b1;
        shadow_d = zn_d[STAGES-1];
        seen_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shadow_q <= '1;
      seen_q   <= 1'b0;
      chg_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      seen_q   <= seen_d;
      chg_q    <= chg_d;
    end
  end

  assign CHG = chg_q;
`endif

`ifndef FUNCTIONAL
  specify
    (CLK *> ZN) = (1.0, 1.0);
    (CLK => VO) = (1.0, 1.0);
    $setuphold(posedge CLK, A, 0.0, 0.0);
    $setuphold(posedge CLK, VI, 0.0, 0.0);
    $setuphold(posedge CLK, EN, 0.0, 0.0);
  endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_nandn_pipe.sv
// Randomised self-checking bench for gf180mcu_nandn_pipe: two configurations against a queue-based model.
module tb_gf180mcu_nandn_pipe;
  localparam int NIN0 = 4, NCH0 = 2, ST0 = 3;
  localparam int NIN1 = 3, NCH1 = 1, ST1 = 1;
  localparam logic [31:0] ONES0 = 32'h3;
  localparam logic [31:0] ONES1 = 32'h1;

  logic                 CLK = 1'b0;
  logic                 RST, MODE, VI, EN;
  logic [NCH0*NIN0-1:0] a0;
  logic [NCH1*NIN1-1:0] a1;
  logic [NCH0-1:0]      zn0;
  logic [NCH1-1:0]      zn1;
  logic                 vo0, vo1;
`ifdef USE_POWER_PINS
  wire VDD, VSS;
`endif
`ifdef GF180MCU_NANDN_PIPE_CHG_DET_EN
  logic chg0, chg1;
`endif

  gf180mcu_nandn_pipe #(.NIN(NIN0), .NCH(NCH0), .STAGES(ST0)) u_dut0 (
`ifdef USE_POWER_PINS
    .VDD(VDD), .VSS(VSS),
`endif
    .CLK(CLK), .RST(RST), .A(a0), .MODE(MODE), .VI(VI), .EN(EN), .ZN(zn0), .VO(vo0)
`ifdef GF180MCU_NANDN_PIPE_CHG_DET_EN
    , .CHG(chg0)
`endif
  );

  gf180mcu_nandn_pipe #(.NIN(NIN1), .NCH(NCH1), .STAGES(ST1)) u_dut1 (
`ifdef USE_POWER_PINS
    .VDD(VDD), .VSS(VSS),
`endif
    .CLK(CLK), .RST(RST), .A(a1), .MODE(MODE), .VI(VI), .EN(EN), .ZN(zn1), .VO(vo1)
`ifdef GF180MCU_NANDN_PIPE_CHG_DET_EN
    , .CHG(chg1)
`endif
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each advancing edge pushes the captured word; the output is the
  // word captured ST advancing edges ago, or the reset word if fewer edges have passed.
  logic [31:0] q0d[$], q1d[$];
  bit          q0v[$], q1v[$];
  logic [31:0] sh0, sh1;
  bit          seen0, seen1, ch0, ch1;

  function automatic logic [31:0] red(input logic [31:0] a, input int nin, input int nch,
                                      input logic mode);
    logic [31:0] r;
    logic [31:0] m;
    logic [31:0] field;
    r = 32'd0;
    m = (32'd1 << nin) - 32'd1;
    for (int c = 0; c < nch; c++) begin
      field = (a >> (c * nin)) & m;
      r[c]  = mode ? (field == m) : (field != m);
    end
    return r;
  endfunction

  task automatic model_reset();
    q0d.delete(); q0v.delete(); q1d.delete(); q1v.delete();
    sh0 = ONES0; sh1 = ONES1;
    seen0 = 0; seen1 = 0; ch0 = 0; ch1 = 0;
  endtask

  task automatic model_adv();
    q0d.push_front(red(32'(a0), NIN0, NCH0, MODE)); q0v.push_front(VI);
    q1d.push_front(red(32'(a1), NIN1, NCH1, MODE)); q1v.push_front(VI);
    if (q0d.size() > ST0) begin void'(q0d.pop_back()); void'(q0v.pop_back()); end
    if (q1d.size() > ST1) begin void'(q1d.pop_back()); void'(q1v.pop_back()); end
    if (q0d.size() == ST0 && q0v[ST0-1] && (!seen0 || q0d[ST0-1] != sh0)) begin
      ch0 = 1; sh0 = q0d[ST0-1]; seen0 = 1;
    end else ch0 = 0;
    if (q1d.size() == ST1 && q1v[ST1-1] && (!seen1 || q1d[ST1-1] != sh1)) begin
      ch1 = 1; sh1 = q1d[ST1-1]; seen1 = 1;
    end else ch1 = 0;
  endtask

  task automatic cmp(input string tag);
    check_eq({tag, ".zn0"}, 32'(zn0), (q0d.size() == ST0) ? q0d[ST0-1] : ONES0);
    check_eq({tag, ".vo0"}, 32'(vo0), (q0d.size() == ST0) ? 32'(q0v[ST0-1]) : 32'd0);
    check_eq({tag, ".zn1"}, 32'(zn1), (q1d.size() == ST1) ? q1d[ST1-1] : ONES1);
    check_eq({tag, ".vo1"}, 32'(vo1), (q1d.size() == ST1) ? 32'(q1v[ST1-1]) : 32'd0);
`ifdef GF180MCU_NANDN_PIPE_CHG_DET_EN
    check_eq({tag, ".chg0"}, 32'(chg0), 32'(ch0));
    check_eq({tag, ".chg1"}, 32'(chg1), 32'(ch1));
`endif
  endtask

  task automatic cyc(input string tag);
    @(posedge CLK);
    if (RST) model_reset();
    else if (EN) model_adv();
    #1;
    cmp(tag);
  endtask

  task automatic rand_inputs();
    a0 = 8'($urandom) | ($urandom_range(0, 1) ? 8'h0F : 8'h00)
                      | ($urandom_range(0, 1) ? 8'hF0 : 8'h00);
    a1 = 3'($urandom) | ($urandom_range(0, 1) ? 3'h7 : 3'h0);
  endtask

  task automatic do_reset();
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    cmp("rst_async");
    cyc("rst_hold");
    RST = 1'b0;
  endtask

  int exp_chg [5];

  initial begin
    RST = 1'b1; MODE = 1'b0; VI = 1'b0; EN = 1'b0; a0 = '0; a1 = '0;
    model_reset();
    #3;
    cmp("reset");
    cyc("reset_edge");
    RST = 1'b0;

    // NAND truth table on the 3-input single-channel instance
    MODE = 1'b0; VI = 1'b1; EN = 1'b1;
    for (int a = 0; a < 8; a++) begin
      a1 = 3'(a);
      a0 = 8'($urandom);
      cyc("truth");
      check_eq("truth_zn", 32'(zn1), (a == 7) ? 32'd0 : 32'd1);
      check_eq("truth_vo", 32'(vo1), 32'd1);
    end

    // AND mode across two channels: 8'hF7 gives channel1=1, channel0=0
    MODE = 1'b1; a0 = 8'hF7; VI = 1'b1; EN = 1'b1;
    cyc("mc0");
    VI = 1'b0; MODE = 1'b0;
    rand_inputs(); cyc("mc1");
    rand_inputs(); cyc("mc2");
    check_eq("mc_zn", 32'(zn0), 32'h2);
    check_eq("mc_vo", 32'(vo0), 32'd1);

    // Stall with a word in flight; A and VI churn during the stall
    MODE = 1'b1; a0 = 8'hF7; VI = 1'b1; EN = 1'b1;
    cyc("st0");
    EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_inputs(); VI = 1'($urandom); MODE = 1'($urandom);
      cyc("stall");
    end
    EN = 1'b1; VI = 1'b0; MODE = 1'b0;
    rand_inputs(); cyc("st1");
    rand_inputs(); cyc("st2");
    check_eq("stall_zn", 32'(zn0), 32'h2);
    check_eq("stall_vo", 32'(vo0), 32'd1);

    // Alternating valid gaps
    EN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      VI = 1'(i % 2); MODE = 1'($urandom);
      rand_inputs(); cyc("gaps");
    end

    // Mid-run asynchronous reset with valid words in flight
    VI = 1'b1; EN = 1'b1;
    rand_inputs(); cyc("pre_rst");
    do_reset();
    check_eq("rst_zn0", 32'(zn0), ONES0);
    check_eq("rst_vo0", 32'(vo0), 32'd0);
    VI = 1'b1;
    for (int i = 0; i < ST0; i++) begin
      rand_inputs(); cyc("post_rst");
      if (i < ST0 - 1) check_eq("post_rst_vo0", 32'(vo0), 32'd0);
    end
    check_eq("post_rst_vo0_done", 32'(vo0), 32'd1);

    // Randomised traffic including stalls, gaps and mode changes
    for (int i = 0; i < 400; i++) begin
      EN   = ($urandom_range(0, 3) != 0);
      VI   = 1'($urandom);
      MODE = 1'($urandom);
      rand_inputs();
      cyc("rand");
    end

`ifdef GF180MCU_NANDN_PIPE_CHG_DET_EN
    // Output word sequence 1,1,0,0,1 on the single-stage instance
    do_reset();
    exp_chg = '{1, 0, 1, 0, 1};
    MODE = 1'b0; EN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      VI = 1'b1;
      a1 = (i == 2 || i == 3) ? 3'h7 : 3'h0;
      cyc("chg_seq");
      check_eq("chg_pattern", 32'(chg1), 32'(exp_chg[i]));
      VI = 1'b0; a1 = 3'h7;
      cyc("chg_gap");
      check_eq("chg_gap_zero", 32'(chg1), 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
